// File: rtl/deser_pkg.sv
// Shared types and elaboration helpers for the multi-lane deserializer.
// Optional idle-timeout abort is enabled by defining DESER_TIMEOUT_EN.
package deser_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } deser_state_t;

  function automatic int beats_f(input int w, input int lanes);
    return w / lanes;
  endfunction

  function automatic int len_w_f(input int w);
    return $clog2(w + 1);
  endfunction

  // The beat counter needs at least one bit even when a single beat fills the word.
  function automatic int cnt_w_f(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/deser_idle_timer.sv
// Counts consecutive idle cycles while a word is being collected and flags the
// cycle on which the TIMEOUT-th idle cycle is reached (used only with DESER_TIMEOUT_EN).
module deser_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_beat,
  output logic o_expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_idle_cnt;

  // A beat on the terminal cycle suppresses the expiry, so the beat always wins.
  assign o_expire = i_run && !i_beat && (r_idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle_cnt <= '0;
    end else if (!i_run || i_beat || o_expire) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/deserializer_mlane.sv
// Multi-lane deserializer: packs LANES bits per valid beat into a W-bit word, MSB- or
// LSB-first, with early termination and length reporting. Define DESER_TIMEOUT_EN for idle abort.
module deserializer_mlane
  import deser_pkg::*;
#(
  parameter int W         = 16,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic [LANES-1:0]       data_i,
  input  logic                   data_val_i,
  input  logic                   data_last_i,
  output logic [W-1:0]           deser_data_o,
  output logic [len_w_f(W)-1:0]  deser_len_o,
  output logic                   deser_data_val_o,
  output logic                   deser_err_o
);

  localparam int BEATS = beats_f(W, LANES);
  localparam int LEN_W = len_w_f(W);
  localparam int CNT_W = cnt_w_f(BEATS);

  if ((W % LANES) != 0 || LANES > W || LANES < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("deserializer_mlane: illegal W/LANES/TIMEOUT combination");
  end

  deser_state_t     r_state;
  deser_state_t     w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_sr;
  logic [W-1:0]     r_data;
  logic [LEN_W-1:0] r_len;
  logic             r_val;
  logic [1:0]       r_rst_sync;

  logic             w_rst_n;
  logic             w_last_beat;
  logic             w_close;
  logic             w_tmo;
  logic             w_emit;
  logic             w_shift;
  logic             w_abort;
  logic             w_collect;
  logic [W-1:0]     w_sr_shift;
  logic [W-1:0]     w_aligned;
  logic [LEN_W-1:0] w_pad;
  logic [LEN_W-1:0] w_len;

  // Reset asserts immediately but is released only after two clean clock edges.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_collect   = (r_state == COLLECT);
  assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
  assign w_close     = data_val_i && (data_last_i || w_last_beat);

  // Shift register input: the earliest bit of each beat always ends up nearer the
  // side the word is filled from, so data_i is inserted unreordered.
  if (LANES == W) begin : g_full_lane
    assign w_sr_shift = data_i;
  end else if (MSB_FIRST != 0) begin : g_msb_shift
    assign w_sr_shift = {r_sr[W-LANES-1:0], data_i};
  end else begin : g_lsb_shift
    assign w_sr_shift = {data_i, r_sr[W-1:LANES]};
  end

  // Beats still missing from a short word decide how far to justify it.
  assign w_pad = LEN_W'((BEATS - 1 - int'(r_cnt)) * LANES);
  assign w_len = LEN_W'((int'(r_cnt) + 1) * LANES);

  if (MSB_FIRST != 0) begin : g_msb_align
    assign w_aligned = w_sr_shift << w_pad;
  end else begin : g_lsb_align
    assign w_aligned = w_sr_shift >> w_pad;
  end

`ifdef DESER_TIMEOUT_EN
  logic r_err;

  deser_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .i_clk    (clk_i),
    .i_rst_n  (w_rst_n),
    .i_run    (w_collect),
    .i_beat   (data_val_i),
    .o_expire (w_tmo)
  );

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_abort;
    end
  end

  assign deser_err_o = r_err;
`else
  assign w_tmo       = 1'b0;
  assign deser_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (data_val_i && !w_close) begin
          w_state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (w_close || w_tmo) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_emit  = 1'b0;
    w_shift = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        w_emit  = w_close;
        w_shift = data_val_i && !w_close;
      end
      COLLECT: begin
        w_emit  = w_close;
        w_shift = data_val_i && !w_close;
        w_abort = w_tmo;
      end
      default: begin
        w_abort = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt  <= '0;
      r_sr   <= '0;
      r_data <= '0;
      r_len  <= '0;
      r_val  <= 1'b0;
    end else begin
      r_val <= w_emit;
      if (w_emit) begin
        r_cnt  <= '0;
        r_sr   <= '0;
        r_data <= w_aligned;
        r_len  <= w_len;
      end else if (w_shift) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_sr  <= w_sr_shift;
      end else if (w_abort) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_len_o      = r_len;
  assign deser_data_val_o = r_val;

endmodule
